bit8_mem_loader: RTL and testbench
==================================

// Module: bit8_mem_loader
// PURPOSE
//   Program/data memory and boot loader for the 8-bit state-machine core.
//   After reset it accepts a program as a byte stream with a valid/ready handshake and holds the core in reset.
//   It then releases the core and serves the core's addr/data/rw bus: async read, sync write, and one memory-mapped in/out port.
//   Sits directly on the core bus. Top level splits the core's inout data into cpu_wdata/cpu_rdata.
// PARAMETERS
//   AW       8      address width; memory depth = 2**AW bytes
//   DW       8      data width
//   OUT_ADDR 8'hFF  write-only output port address (not backed by RAM)
//   IN_ADDR  8'hFE  read-only input port address (not backed by RAM)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous reset, active-low
//   ld_valid   in   1   loader byte valid
//   ld_data    in   DW  loader byte
//   ld_last    in   1   marks final loader byte (qualified by ld_valid)
//   ld_ready   out  1   loader may transfer this cycle
//   reload     in   1   1-cycle pulse: re-enter LOAD from RUN
//   core_rst_n out  1   active-low reset to core; high only in RUN
//   loaded     out  1   program loaded, core running
//   ld_count   out  AW+1 bytes accepted in current/last load
//   cpu_addr   in   AW  core address
//   cpu_rw     in   1   1 = core write, 0 = core read
//   cpu_wdata  in   DW  core write data
//   cpu_rdata  out  DW  read data to core
//   port_in    in   DW  external input port
//   port_out   out  DW  external output latch
// BEHAVIOUR
//   Reset (rst=0 at posedge): state=LOAD, wptr=0, ld_count=0, port_out=0, core_rst_n=0, loaded=0. RAM array is not cleared.
//   All outputs except cpu_rdata are registered. ld_ready=(state==LOAD), decoded from the registered state.
//   LOAD:
//     - Transfer when ld_valid&&ld_ready: mem[wptr]<=ld_data, wptr++, ld_count++.
//     - The transfer carrying ld_last, or the one at wptr==2**AW-1, moves the state to START. wptr never wraps.
//     - ld_valid=0 stalls indefinitely; no timeout.
//   START (1 cycle): ld_ready=0, core_rst_n stays 0, port_out<=0. Next state is RUN.
//   RUN:
//     - core_rst_n=1 and loaded=1 from the first RUN cycle. ld_valid is ignored.
//     - Read: cpu_rdata is combinational. It is port_in if cpu_addr==IN_ADDR, else mem[cpu_addr]. Zero latency, because the core samples data one edge after it drives addr.
//     - Write: at posedge with cpu_rw=1:
//         cpu_addr==OUT_ADDR -> port_out<=cpu_wdata
//         cpu_addr==IN_ADDR  -> dropped
//         otherwise          -> mem[cpu_addr]<=cpu_wdata
//     - reload=1: next state LOAD, wptr<=0, ld_count<=0, core_rst_n<=0, loaded<=0. A cpu write in the same cycle is dropped (reload wins).
//   In LOAD/START: cpu_rdata=0 and all cpu writes are ignored (core held in reset; its rw is unreliable).
//   reload outside RUN: ignored.
//   rst low mid-load: returns to LOAD with wptr=0. Partially written bytes remain in RAM but will be overwritten.
//   ld_count width AW+1, so a full 2**AW load is representable.
// STRUCTURE
//   Shared package bit8_pkg:
//     - state enum {LOAD, START, RUN}
//     - default OUT_ADDR/IN_ADDR constants
//     - DW constant, shared with the core
//   Sub-module bit8_ram: 2**AW x DW array with sync write and async read; no reset.
//   Top: FSM, wptr/ld_count counters, port decode, write-port mux (loader vs cpu).
// TESTING
//   1. Load 4 bytes A0,A1,A2,A3 with ld_last on A3 -> ld_count=4, one START cycle, then core_rst_n=1 and loaded=1. In RUN, addr 0..3 reads A0..A3.
//   2. Stall: ld_valid toggles 1,0,0,1 -> exactly 2 bytes written at wptr 0,1; ld_count=2.
//   3. Full load of 256 bytes with no ld_last -> START after byte 255; ld_count=9'h100.
//   4. RUN: write 8'h5A to addr 8'hFF -> port_out=5A and RAM unchanged. Write 8'h33 to addr 8'h10 -> reading addr 8'h10 gives 33. port_in=C3 -> reading 8'hFE gives C3.
//   5. reload pulse together with a cpu write to 8'h20 -> write dropped. Next cycle LOAD, core_rst_n=0, ld_ready=1, ld_count=0.
//   6. rst low during load after 2 bytes -> next cycle LOAD with ld_count=0 and port_out=0. Loading 1 byte with ld_last overwrites mem[0].

Source files
------------

// File: rtl/bit8_pkg.sv
// Shared definitions for the 8-bit state-machine core and its memory/boot loader.
package bit8_pkg;

    localparam int DW = 8;

    localparam logic [7:0] OUT_ADDR = 8'hFF;
    localparam logic [7:0] IN_ADDR  = 8'hFE;

    typedef enum logic [1:0] {
        LOAD,
        START,
        RUN
    } state_e;

endpackage

// File: rtl/bit8_mem_loader_if.sv
// Loader byte-stream handshake plus the core's addr/data/rw bus, with data split into wdata/rdata.
interface bit8_mem_loader_if #(
    parameter int AW = 8,
    parameter int DW = bit8_pkg::DW
) ();

    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;

    logic [AW-1:0] cpu_addr;
    logic          cpu_rw;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;

    modport master (
        output ld_valid, ld_data, ld_last, cpu_addr, cpu_rw, cpu_wdata,
        input  ld_ready, cpu_rdata
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, cpu_addr, cpu_rw, cpu_wdata,
        output ld_ready, cpu_rdata
    );

endinterface

// File: rtl/bit8_ram.sv
// Program/data store: 2**AW x DW, synchronous write, asynchronous read, contents survive reset.
module bit8_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bit8_mem_loader.sv
// Boot loader and memory for the 8-bit core: streams a program into RAM while holding
// the core in reset, then serves the core bus with one memory-mapped in/out port pair.
module bit8_mem_loader #(
    parameter int            AW       = 8,
    parameter int            DW       = bit8_pkg::DW,
    parameter logic [AW-1:0] OUT_ADDR = bit8_pkg::OUT_ADDR,
    parameter logic [AW-1:0] IN_ADDR  = bit8_pkg::IN_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    bit8_mem_loader_if.slave  bus,
    input  logic              reload,
    output logic              core_rst_n,
    output logic              loaded,
    output logic [AW:0]       ld_count,
    input  logic [DW-1:0]     port_in,
    output logic [DW-1:0]     port_out
);

    import bit8_pkg::*;

    localparam logic [AW-1:0] WPTR_MAX = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   ld_count_q, ld_count_d;
    logic          core_rst_n_q, core_rst_n_d;
    logic          loaded_q, loaded_d;
    logic [DW-1:0] port_out_q, port_out_d;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        ld_count_d   = ld_count_q;
        core_rst_n_d = core_rst_n_q;
        loaded_d     = loaded_q;
        port_out_d   = port_out_q;
        ram_we       = 1'b0;
        ram_waddr    = wptr_q;
        ram_wdata    = bus.ld_data;

        case (state_q)
            LOAD: begin
                if (bus.ld_valid) begin
                    ram_we     = 1'b1;
                    ld_count_d = ld_count_q + 1'b1;
                    // The pointer saturates at the top so a full-depth load never wraps onto byte 0.
                    if (wptr_q != WPTR_MAX) begin
                        wptr_d = wptr_q + 1'b1;
                    end
                    if (bus.ld_last || (wptr_q == WPTR_MAX)) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                state_d      = RUN;
                port_out_d   = '0;
                core_rst_n_d = 1'b1;
                loaded_d     = 1'b1;
            end
            RUN: begin
                if (reload) begin
                    state_d      = LOAD;
                    wptr_d       = '0;
                    ld_count_d   = '0;
                    core_rst_n_d = 1'b0;
                    loaded_d     = 1'b0;
                end else if (bus.cpu_rw) begin
                    if (bus.cpu_addr == OUT_ADDR) begin
                        port_out_d = bus.cpu_wdata;
                    end else if (bus.cpu_addr != IN_ADDR) begin
                        ram_we    = 1'b1;
                        ram_waddr = bus.cpu_addr;
                        ram_wdata = bus.cpu_wdata;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= LOAD;
            wptr_q       <= '0;
            ld_count_q   <= '0;
            core_rst_n_q <= 1'b0;
            loaded_q     <= 1'b0;
            port_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            ld_count_q   <= ld_count_d;
            core_rst_n_q <= core_rst_n_d;
            loaded_q     <= loaded_d;
            port_out_q   <= port_out_d;
        end
    end

    bit8_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (bus.cpu_addr),
        .rdata (ram_rdata)
    );

    // Read data is zero-latency; the core is in reset outside RUN, so it sees zeros there.
    assign bus.cpu_rdata = (state_q != RUN)          ? '0      :
                           (bus.cpu_addr == IN_ADDR) ? port_in : ram_rdata;

    assign bus.ld_ready = (state_q == LOAD);
    assign core_rst_n   = core_rst_n_q;
    assign loaded       = loaded_q;
    assign ld_count     = ld_count_q;
    assign port_out     = port_out_q;

endmodule

// File: tb/tb_bit8_mem_loader.sv
// Randomized bench for bit8_mem_loader against an array-based memory/loader model.
module tb_bit8_mem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       reload;
    logic       core_rst_n;
    logic       loaded;
    logic [8:0] ld_count;
    logic [7:0] port_in;
    logic [7:0] port_out;

    bit8_mem_loader_if #(.AW(8), .DW(8)) bus ();

    bit8_mem_loader #(.AW(8), .DW(8), .OUT_ADDR(8'hFF), .IN_ADDR(8'hFE)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .reload     (reload),
        .core_rst_n (core_rst_n),
        .loaded     (loaded),
        .ld_count   (ld_count),
        .port_in    (port_in),
        .port_out   (port_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] refMem [256];
    int         refWptr;
    int         refCount;
    logic [7:0] refPortOut;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random core bus activity while the core is held in reset; it must never reach RAM.
    task automatic applyStimulus();
        bus.cpu_rw    = 1'($urandom);
        bus.cpu_addr  = 8'($urandom);
        bus.cpu_wdata = 8'($urandom);
    endtask

    task automatic pushByte(input logic [7:0] data, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = data;
        bus.ld_last  = last;
        applyStimulus();
        tick();
        refMem[refWptr] = data;
        refCount++;
        if (refWptr < 255) refWptr++;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        checkOutput("ld_count", 32'(ld_count), 32'(refCount));
    endtask

    task automatic stallCycle();
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'($urandom);
        bus.ld_last  = 1'($urandom);
        applyStimulus();
        tick();
        checkOutput("stall_ready", 32'(bus.ld_ready), 32'd1);
    endtask

    task automatic loadBytes(input int n, input bit useLast);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) stallCycle();
            pushByte(8'($urandom), useLast && (i == n - 1));
        end
    endtask

    task automatic enterRun();
        bus.cpu_rw = 1'b0;
        checkOutput("start_ready", 32'(bus.ld_ready), 32'd0);
        checkOutput("start_core_rst_n", 32'(core_rst_n), 32'd0);
        checkOutput("start_loaded", 32'(loaded), 32'd0);
        tick();
        refPortOut = 8'h00;
        checkOutput("run_core_rst_n", 32'(core_rst_n), 32'd1);
        checkOutput("run_loaded", 32'(loaded), 32'd1);
        checkOutput("run_ready", 32'(bus.ld_ready), 32'd0);
        checkOutput("run_port_out", 32'(port_out), 32'(refPortOut));
    endtask

    task automatic readCheck(input string tag, input logic [7:0] addr);
        logic [7:0] exp;
        bus.cpu_rw   = 1'b0;
        bus.cpu_addr = addr;
        exp = (addr == 8'hFE) ? port_in : refMem[addr];
        #1;
        checkOutput(tag, 32'(bus.cpu_rdata), 32'(exp));
    endtask

    task automatic cpuWrite(input logic [7:0] addr, input logic [7:0] data);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
        bus.cpu_rw    = 1'b1;
        tick();
        bus.cpu_rw = 1'b0;
        if (addr == 8'hFF) refPortOut = data;
        else if (addr != 8'hFE) refMem[addr] = data;
        checkOutput("wr_port_out", 32'(port_out), 32'(refPortOut));
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        refWptr  = 0;
        refCount = 0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        rst = 1'b0; reload = 1'b0; port_in = 8'h00;
        bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.ld_last = 1'b0;
        bus.cpu_addr = 8'h00; bus.cpu_rw = 1'b0; bus.cpu_wdata = 8'h00;
        refWptr = 0; refCount = 0; refPortOut = 8'h00;
        tick(); tick();
        checkOutput("rst_ready", 32'(bus.ld_ready), 32'd1);
        checkOutput("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        checkOutput("rst_loaded", 32'(loaded), 32'd0);
        checkOutput("rst_ld_count", 32'(ld_count), 32'd0);
        checkOutput("rst_port_out", 32'(port_out), 32'd0);
        checkOutput("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        rst = 1'b1;

        $display("[TB] four-byte program");
        pushByte(8'hA0, 1'b0); pushByte(8'hA1, 1'b0);
        pushByte(8'hA2, 1'b0); pushByte(8'hA3, 1'b1);
        enterRun();
        for (int a = 0; a < 4; a++) readCheck("prog_read", 8'(a));
        bus.ld_valid = 1'b1; bus.ld_last = 1'b1; bus.ld_data = 8'hEE;
        tick();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        checkOutput("run_ignores_ld", 32'(ld_count), 32'd4);
        readCheck("run_ignores_ld_mem", 8'h00);

        $display("[TB] stalled load");
        pulseReload();
        checkOutput("reload_ready", 32'(bus.ld_ready), 32'd1);
        pushByte(8'hB0, 1'b0);
        stallCycle(); stallCycle();
        pushByte(8'hB1, 1'b0);
        checkOutput("stall_count", 32'(ld_count), 32'd2);
        pushByte(8'hB2, 1'b1);
        enterRun();
        for (int a = 0; a < 4; a++) readCheck("stall_read", 8'(a));

        $display("[TB] full-depth load");
        pulseReload();
        loadBytes(256, 1'b0);
        checkOutput("full_count", 32'(ld_count), 32'h100);
        enterRun();
        for (int k = 0; k < 32; k++) begin
            port_in = 8'($urandom);
            readCheck("full_read", 8'($urandom));
        end

        $display("[TB] run-mode bus");
        b = refMem[8'hFF];
        cpuWrite(8'hFF, 8'h5A);
        checkOutput("out_port", 32'(port_out), 32'h5A);
        readCheck("out_ram_kept", 8'hFF);
        checkOutput("out_ram_val", 32'(refMem[8'hFF]), 32'(b));
        cpuWrite(8'h10, 8'h33);
        readCheck("ram_write", 8'h10);
        port_in = 8'hC3;
        readCheck("in_port", 8'hFE);
        cpuWrite(8'hFE, 8'h77);
        readCheck("in_port_kept", 8'hFE);
        for (int k = 0; k < 40; k++) begin
            port_in = 8'($urandom);
            if ($urandom_range(0, 1) == 1) cpuWrite(8'($urandom_range(240, 255)), 8'($urandom));
            else readCheck("rand_read", 8'($urandom_range(240, 255)));
        end
        cpuWrite(8'hFF, 8'h5A);

        $display("[TB] reload with colliding write");
        bus.cpu_addr = 8'h20; bus.cpu_wdata = ~refMem[8'h20]; bus.cpu_rw = 1'b1;
        pulseReload();
        bus.cpu_rw = 1'b0;
        checkOutput("rl_ready", 32'(bus.ld_ready), 32'd1);
        checkOutput("rl_core_rst_n", 32'(core_rst_n), 32'd0);
        checkOutput("rl_loaded", 32'(loaded), 32'd0);
        checkOutput("rl_count", 32'(ld_count), 32'd0);
        checkOutput("rl_port_out", 32'(port_out), 32'h5A);
        #1;
        checkOutput("rl_rdata", 32'(bus.cpu_rdata), 32'd0);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checkOutput("reload_in_load", 32'(bus.ld_ready), 32'd1);
        pushByte(8'($urandom), 1'b1);
        enterRun();
        readCheck("rl_dropped", 8'h20);
        readCheck("rl_byte0", 8'h00);

        $display("[TB] reset mid-load");
        cpuWrite(8'hFF, 8'h96);
        pulseReload();
        pushByte(8'($urandom), 1'b0);
        pushByte(8'($urandom), 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        refWptr = 0; refCount = 0; refPortOut = 8'h00;
        checkOutput("mid_rst_count", 32'(ld_count), 32'd0);
        checkOutput("mid_rst_port_out", 32'(port_out), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus.ld_ready), 32'd1);
        pushByte(8'h6C, 1'b1);
        enterRun();
        readCheck("mid_rst_byte0", 8'h00);
        readCheck("mid_rst_byte1", 8'h01);
        readCheck("mid_rst_0x20", 8'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
